// File: rtl/canny_sram_pkg.sv
// Shared defaults and FSM state encoding for the frame-buffer SRAM arbiter.
package canny_sram_pkg;

   localparam int unsigned ADDR_W_DEF    = 18;
   localparam int unsigned DATA_W_DEF    = 8;
   localparam int unsigned LAST_ADDR_DEF = 262143;
   localparam int unsigned READ_LAT_DEF  = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/sram_arbiter_rd_valid_pipe.sv
// READ_LAT-deep valid shift register tracking reads in flight inside the SRAM.
module rd_valid_pipe #(
   parameter int unsigned DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic valid_in,
   output logic valid_out
);

   logic [DEPTH-1:0] stage;

   // NOTE: the async clear is what kills reads in flight; data is not tracked here at all.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage <= '0;
      end else begin
         stage[0] <= valid_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign valid_out = stage[DEPTH-1];

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter between a pixel reader and a frame writer.
// Define SRAM_ARB_WR_PRIO_EN to make writes win every tie instead of round-robin.
module sram_arbiter
   import canny_sram_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned READ_LAT  = READ_LAT_DEF,
   parameter int unsigned LAST_ADDR = LAST_ADDR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_gnt,
   output logic              frame_done,
   output logic              sram_re,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   arb_state_t       state;
   logic             pick_wr;
   logic [DATA_W-1:0] rd_data_q;

`ifdef SRAM_ARB_WR_PRIO_EN
   assign pick_wr = wr_req;
`else
   // last_wr remembers who was served last so a tie goes to the other side.
   logic last_wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_wr <= 1'b1;
      end else if (state == IDLE && (rd_req || wr_req)) begin
         last_wr <= pick_wr;
      end
   end

   assign pick_wr = wr_req && (!rd_req || !last_wr);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rd_gnt     <= 1'b0;
         wr_gnt     <= 1'b0;
         sram_re    <= 1'b0;
         sram_we    <= 1'b0;
         frame_done <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         // NOTE: pulses default low each cycle; address and write data deliberately hold.
         rd_gnt     <= 1'b0;
         wr_gnt     <= 1'b0;
         sram_re    <= 1'b0;
         sram_we    <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_wr) begin
                  state      <= WR;
                  wr_gnt     <= 1'b1;
                  sram_we    <= 1'b1;
                  sram_addr  <= wr_addr;
                  sram_wdata <= wr_data;
               end else if (rd_req) begin
                  state     <= RD;
                  rd_gnt    <= 1'b1;
                  sram_re   <= 1'b1;
                  sram_addr <= rd_addr;
               end
            end
            RD: state <= IDLE;
            WR: begin
               state      <= IDLE;
               frame_done <= (sram_addr == ADDR_W'(LAST_ADDR));
            end
            default: state <= IDLE;
         endcase
      end
   end

   rd_valid_pipe #(
      .DEPTH (READ_LAT)
   ) u_rd_valid_pipe (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (sram_re),
      .valid_out (rd_valid)
   );

   // rd_data passes the SRAM word through on the valid cycle and holds it afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (rd_valid) begin
         rd_data_q <= sram_rdata;
      end
   end

   assign rd_data = rd_valid ? sram_rdata : rd_data_q;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, 18, SRAM word-address width (512 x 512 frame).
REQ-002 Parameter DATA_W, 8, pixel width.
REQ-003 Parameter READ_LAT, 1, SRAM read latency in cycles (legal 1..3).
REQ-004 Parameter LAST_ADDR, 262143, final frame address; a write here ends the frame.
REQ-005 clk  in  1  sole clock, rising edge; one clock; reset is asynchronous and active-high.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 rd_req  in  1  read requester wants an access; held until rd_gnt.
REQ-008 rd_addr  in  ADDR_W  read address, stable while rd_req high.
REQ-009 rd_gnt  out  1  one-cycle pulse, read issued this cycle.
REQ-010 rd_data  out  DATA_W  returned read pixel.
REQ-011 rd_valid  out  1  one-cycle pulse, rd_data valid.
REQ-012 wr_req  in  1  write requester (write controller) wants an access; held until wr_gnt.
REQ-013 wr_addr  in  ADDR_W  write address, stable while wr_req high.
REQ-014 wr_data  in  DATA_W  write pixel, stable while wr_req high.
REQ-015 wr_gnt  out  1  one-cycle pulse, write issued this cycle.
REQ-016 frame_done  out  1  one-cycle pulse after the LAST_ADDR write.
REQ-017 sram_re / sram_we  out  1 each  SRAM strobes, never both high.
REQ-018 sram_addr  out  ADDR_W; sram_wdata  out  DATA_W; sram_rdata  in  DATA_W.

Function
REQ-019 FSM states IDLE, RD, WR; all SRAM-side outputs and grants are registered.
REQ-020 IDLE: no request -> IDLE; only rd_req -> RD; only wr_req -> WR; both -> per REQ-023.
REQ-021 RD and WR last exactly one cycle, then always return to IDLE; peak throughput one access per 2 cycles.
REQ-022 In RD: sram_re=1, sram_addr=rd_addr sampled in IDLE, rd_gnt=1; in WR: sram_we=1, sram_addr/sram_wdata=wr_addr/wr_data sampled in IDLE, wr_gnt=1.
REQ-023 Simultaneous requests: grant the requester not served last (round-robin via last_wr flag).
REQ-024 Outside RD/WR: strobes and grants 0; sram_addr/sram_wdata hold last value.
REQ-025 rd_valid asserts exactly READ_LAT cycles after the RD cycle, with rd_data = sram_rdata sampled that cycle; rd_data holds between pulses.
REQ-026 frame_done pulses the cycle after a WR cycle whose address equals LAST_ADDR; no pulse for any other address.
REQ-027 A requester dropping req while in IDLE before grant cancels its request with no side effect.

Reset
REQ-028 rst high: state IDLE, all outputs 0, last_wr=1 (read wins first tie), read-valid pipeline cleared.
REQ-029 rst asserted mid-access or with reads in flight: no rd_valid is ever produced for those reads after release.

Configuration
REQ-030 Macro SRAM_ARB_WR_PRIO_EN defined: on simultaneous requests write always wins (write-back never stalls the pipeline); last_wr unused.
REQ-031 Macro undefined: round-robin per REQ-023.

Structure
REQ-032 Package canny_sram_pkg holds ADDR_W/DATA_W defaults, LAST_ADDR default, and the FSM state enum.
REQ-033 Sub-module rd_valid_pipe: READ_LAT-deep shift register of valid bits with async active-high clear.

Verification
REQ-034 rd_req=1, rd_addr=0x00123, READ_LAT=1, sram_rdata=0xA5 -> rd_gnt+sram_re cycle 2, rd_valid with rd_data=0xA5 cycle 3.
REQ-035 wr_req=1, wr_addr=0x3FFFF, wr_data=0xFF -> sram_we with that addr/data, wr_gnt, frame_done next cycle; wr_addr=0x3FE00 -> no frame_done.
REQ-036 rd_req and wr_req held high for 8 cycles, macro undefined -> grants alternate R,W,R,W, strobes never coincident.
REQ-037 Same stimulus with SRAM_ARB_WR_PRIO_EN -> only wr_gnt pulses while wr_req stays high.
REQ-038 READ_LAT=3, rst pulsed 1 cycle after RD -> no rd_valid, all outputs 0, next tie grants read.
